// File: rtl/eight_bit_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// RESULT_W is the width of the concatenated {cout, sum} result.
package eight_bit_adder_pkg;

   localparam int unsigned ADDER_W  = 8;
   localparam int unsigned RESULT_W = ADDER_W + 1;

   typedef logic [ADDER_W-1:0] operand_t;

endpackage

// File: rtl/eight_bit_adder_full_adder.sv
// One-bit combinational full adder.
// Used as a single cell of the ripple-carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   logic half_sum;

   assign half_sum = a ^ b;
   assign s        = half_sum ^ cin;
   assign co       = (a & b) | (cin & half_sum);

endmodule

// File: rtl/eight_bit_adder.sv
// Unsigned adder: ripple chain of full_adder cells plus one output register.
// Result {cout, sum} appears one clock after the operands are sampled.
module eight_bit_adder
   import eight_bit_adder_pkg::*;
#(
   parameter int unsigned WIDTH = ADDER_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] sum_comb;
   logic             cout_comb;

   // Each stage owns its carry so g_ripple[i].co can be probed per bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      logic cin;
      logic co;

      if (i == 0) begin : g_first
         assign cin = 1'b0;
      end else begin : g_next
         assign cin = g_ripple[i-1].co;
      end

      full_adder u_fa (
         .a   (A[i]),
         .b   (B[i]),
         .cin (cin),
         .s   (sum_comb[i]),
         .co  (co)
      );
   end

   assign cout_comb = g_ripple[WIDTH-1].co;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         sum  <= sum_comb;
         cout <= cout_comb;
      end
   end

endmodule

// File: tb/tb_eight_bit_adder.sv
// Directed and exhaustive checks for eight_bit_adder.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_eight_bit_adder;

   logic       clk;
   logic       rst;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] sum;
   logic       cout;

   int checks;
   int failures;

   eight_bit_adder #(.WIDTH(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .A    (A),
      .B    (B),
      .sum  (sum),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [8:0] expected);
      checks++;
      assert ({cout, sum} === expected)
      else begin
         failures++;
         $error("FAIL %s: observed cout=%b sum=%02h, expected cout=%b sum=%02h",
                tag, cout, sum, expected[8], expected[7:0]);
      end
   endtask

   initial begin
      logic [8:0] expected;
      logic [7:0] ta;
      logic [7:0] tb;

      checks   = 0;
      failures = 0;

      // Reset held for two edges with non-zero operands present
      rst = 1'b1;
      A   = 8'hAA;
      B   = 8'h55;
      tick();
      check("reset_edge1", 9'h000);
      tick();
      check("reset_edge2", 9'h000);
      rst = 1'b0;
      tick();
      check("post_reset_AA_55", 9'h0FF);

      // Directed vectors with hand-computed results
      A = 8'h0F; B = 8'hF0; tick(); check("no_carry_0F_F0", 9'h0FF);
      A = 8'h4F; B = 8'hF0; tick(); check("carry_4F_F0",    9'h13F);
      A = 8'hFF; B = 8'h01; tick(); check("wrap_FF_01",     9'h100);
      A = 8'h80; B = 8'h80; tick(); check("wrap_80_80",     9'h100);
      A = 8'hFF; B = 8'hFF; tick(); check("wrap_FF_FF",     9'h1FE);
      A = 8'h00; B = 8'h00; tick(); check("zero_00_00",     9'h000);
      A = 8'h01; B = 8'h7F; tick(); check("ripple_01_7F",   9'h080);

      // Hold: stable inputs keep the outputs stable across further edges
      tick(); check("hold_stable_1", 9'h080);
      tick(); check("hold_stable_2", 9'h080);

      // Back-to-back: new operands every cycle; outputs must not move between edges
      expected = 9'h080;
      for (int i = 0; i < 16; i++) begin
         ta = 8'(i * 37 + 11);
         tb = 8'(255 - i * 19);
         A  = ta;
         B  = tb;
         #3;
         check("b2b_no_comb_change", expected);
         expected = {1'b0, ta} + {1'b0, tb};
         tick();
         check("b2b_latency", expected);
      end

      // Reset asserted for one edge during random traffic
      for (int i = 0; i < 12; i++) begin
         ta  = 8'($urandom);
         tb  = 8'($urandom);
         A   = ta;
         B   = tb;
         rst = (i == 5);
         expected = rst ? 9'h000 : ({1'b0, ta} + {1'b0, tb});
         tick();
         check(rst ? "midstream_reset" : "midstream_traffic", expected);
      end
      rst = 1'b0;

      // Exhaustive operand sweep against the reference sum
      for (int ia = 0; ia < 256; ia++) begin
         for (int ib = 0; ib < 256; ib++) begin
            ta = 8'(ia);
            tb = 8'(ib);
            A  = ta;
            B  = tb;
            tick();
            check("sweep", {1'b0, ta} + {1'b0, tb});
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
